// File: rtl/branch_resolve_ctrl_if.sv
// branch_resolve_ctrl_if
//   Groups the ID-stage branch controller's pipeline-facing signals.
//   master : the pipeline side (drives ID/EX/MEM/WB state, receives stall/redirect)
//   slave  : the branch controller
//   Inputs to the controller:
//     id_branch, id_cmp_op, id_rs, id_rt, id_rs_val, id_rt_val, id_pc_plus4,
//     id_imm16, flush_id, ex_wr_en/ex_wr_addr/ex_is_load,
//     mem_wr_en/mem_wr_addr/mem_is_load/mem_fwd_val, wb_wr_en/wb_wr_addr/wb_val
//   Outputs from the controller:
//     stall, br_taken, br_target, flush_if, br_cnt, taken_cnt
interface branch_resolve_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic            id_branch;
  logic [3:0]      id_cmp_op;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic [PC_W-1:0] id_rs_val;
  logic [PC_W-1:0] id_rt_val;
  logic [PC_W-1:0] id_pc_plus4;
  logic [15:0]     id_imm16;
  logic            flush_id;
  logic            ex_wr_en;
  logic [4:0]      ex_wr_addr;
  logic            ex_is_load;
  logic            mem_wr_en;
  logic [4:0]      mem_wr_addr;
  logic            mem_is_load;
  logic [PC_W-1:0] mem_fwd_val;
  logic            wb_wr_en;
  logic [4:0]      wb_wr_addr;
  logic [PC_W-1:0] wb_val;

  logic             stall;
  logic             br_taken;
  logic [PC_W-1:0]  br_target;
  logic             flush_if;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_branch, id_cmp_op, id_rs, id_rt, id_rs_val, id_rt_val, id_pc_plus4,
           id_imm16, flush_id, ex_wr_en, ex_wr_addr, ex_is_load,
           mem_wr_en, mem_wr_addr, mem_is_load, mem_fwd_val,
           wb_wr_en, wb_wr_addr, wb_val,
    input  stall, br_taken, br_target, flush_if, br_cnt, taken_cnt
  );

  modport slave (
    input  id_branch, id_cmp_op, id_rs, id_rt, id_rs_val, id_rt_val, id_pc_plus4,
           id_imm16, flush_id, ex_wr_en, ex_wr_addr, ex_is_load,
           mem_wr_en, mem_wr_addr, mem_is_load, mem_fwd_val,
           wb_wr_en, wb_wr_addr, wb_val,
    output stall, br_taken, br_target, flush_if, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   ID-stage branch controller for the 5-stage MIPS pipeline. Detects RAW
//   hazards on the branch operands against EX/MEM, stalls IF/ID for 0-2
//   cycles, forwards MEM/WB results into the comparator, drives the PC
//   redirect and counts resolved and taken branches.
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bif    : branch_resolve_ctrl_if.slave (pipeline inputs, stall/redirect/counters)
// Configuration
//   BR_FLUSH_EN : when defined, flush_if follows br_taken (no delay slot);
//                 otherwise flush_if is tied low and the delay slot executes.
module branch_resolve_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  branch_resolve_ctrl_if.slave bif
);

  localparam logic [3:0] OP_BEQ  = 4'b0000;
  localparam logic [3:0] OP_BNE  = 4'b0001;
  localparam logic [3:0] OP_BGEZ = 4'b0100;
  localparam logic [3:0] OP_BGTZ = 4'b0101;
  localparam logic [3:0] OP_BLEZ = 4'b0110;
  localparam logic [3:0] OP_BLTZ = 4'b0111;
  localparam logic [3:0] OP_RTZ  = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q;

  logic             use_rs, use_rt;
  logic [1:0]       haz_rs, haz_rt, haz;
  logic [PC_W-1:0]  rs_f, rt_f;
  logic             cond;
  logic             stall_c, resolve_c, fire;

  // Stall cycles needed before source s can be read through a forward path.
  function automatic logic [1:0] hazard_of(
    input logic [4:0] s,
    input logic ex_en, input logic [4:0] ex_a, input logic ex_ld,
    input logic mem_en, input logic [4:0] mem_a, input logic mem_ld
  );
    if (s == '0)                            return 2'd0;
    if (ex_en && ex_a == s)                 return ex_ld ? 2'd2 : 2'd1;
    if (mem_en && mem_a == s && mem_ld)     return 2'd1;
    return 2'd0;
  endfunction

  // Operand selection: MEM ALU result > WB data > register file.
  function automatic logic [PC_W-1:0] fwd_of(
    input logic [4:0] s, input logic [PC_W-1:0] rf,
    input logic mem_en, input logic [4:0] mem_a, input logic mem_ld,
    input logic [PC_W-1:0] mem_v,
    input logic wb_en, input logic [4:0] wb_a, input logic [PC_W-1:0] wb_v
  );
    if (s != '0 && mem_en && !mem_ld && mem_a == s) return mem_v;
    if (s != '0 && wb_en && wb_a == s)              return wb_v;
    return rf;
  endfunction

  always_comb begin
    use_rs = (bif.id_cmp_op != OP_RTZ);
    use_rt = (bif.id_cmp_op == OP_BEQ) || (bif.id_cmp_op == OP_BNE) ||
             (bif.id_cmp_op == OP_RTZ);
    haz_rs = use_rs ? hazard_of(bif.id_rs, bif.ex_wr_en, bif.ex_wr_addr, bif.ex_is_load,
                                bif.mem_wr_en, bif.mem_wr_addr, bif.mem_is_load) : 2'd0;
    haz_rt = use_rt ? hazard_of(bif.id_rt, bif.ex_wr_en, bif.ex_wr_addr, bif.ex_is_load,
                                bif.mem_wr_en, bif.mem_wr_addr, bif.mem_is_load) : 2'd0;
    haz    = (haz_rs > haz_rt) ? haz_rs : haz_rt;

    rs_f = fwd_of(bif.id_rs, bif.id_rs_val, bif.mem_wr_en, bif.mem_wr_addr, bif.mem_is_load,
                  bif.mem_fwd_val, bif.wb_wr_en, bif.wb_wr_addr, bif.wb_val);
    rt_f = fwd_of(bif.id_rt, bif.id_rt_val, bif.mem_wr_en, bif.mem_wr_addr, bif.mem_is_load,
                  bif.mem_fwd_val, bif.wb_wr_en, bif.wb_wr_addr, bif.wb_val);

    case (bif.id_cmp_op)
      OP_BEQ:  cond = (rs_f == rt_f);
      OP_BNE:  cond = (rs_f != rt_f);
      OP_BGEZ: cond = !rs_f[PC_W-1];
      OP_BGTZ: cond = !rs_f[PC_W-1] && (rs_f != '0);
      OP_BLEZ: cond = rs_f[PC_W-1] || (rs_f == '0);
      OP_BLTZ: cond = rs_f[PC_W-1];
      OP_RTZ:  cond = (rt_f == '0);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    if (bif.flush_id) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bif.id_branch) begin
            if (haz == 2'd0) begin
              resolve_c = 1'b1;
            end else begin
              stall_c = 1'b1;
              cnt_d   = haz - 2'd1;
              state_d = (haz == 2'd1) ? RESOLVE : WAIT;
            end
          end
        end
        WAIT: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RESOLVE;
        end
        RESOLVE: begin
          resolve_c = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fire = resolve_c & bif.id_branch;

  // Outputs are combinational from ID inputs, so they are gated by reset
  // to read as zero the instant reset asserts, even mid-stall.
  assign bif.stall     = stall_c & ~reset;
  assign bif.br_taken  = fire & cond & ~reset;
  assign bif.br_target = bif.id_pc_plus4 + (PC_W'($signed(bif.id_imm16)) << 2);
  assign bif.br_cnt    = br_cnt_q;
  assign bif.taken_cnt = taken_cnt_q;

`ifdef BR_FLUSH_EN
  assign bif.flush_if = bif.br_taken;
`else
  assign bif.flush_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire)        br_cnt_q    <= br_cnt_q + CNT_W'(1);
      if (fire & cond) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl
//   Directed scenarios followed by randomized branches checked against an
//   architectural model: the operand a branch must see is the youngest
//   in-flight producer's result (or the register file), and the stall length
//   is how long that producer's result takes to reach a forward point.
module tb_branch_resolve_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.PC_W(32), .CNT_W(32)) bif ();

  branch_resolve_ctrl #(.PC_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] br_m, tk_m;

  typedef struct packed {
    logic        en;
    logic [4:0]  a;
    logic        ld;
    logic [31:0] res;
  } prod_t;

  prod_t       ex_p, mem_p, wb_p;
  logic [31:0] regs [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bif.id_branch = 0; bif.id_cmp_op = '0; bif.id_rs = '0; bif.id_rt = '0;
    bif.id_rs_val = '0; bif.id_rt_val = '0; bif.id_pc_plus4 = '0; bif.id_imm16 = '0;
    bif.flush_id = 0; bif.ex_wr_en = 0; bif.ex_wr_addr = '0; bif.ex_is_load = 0;
    bif.mem_wr_en = 0; bif.mem_wr_addr = '0; bif.mem_is_load = 0; bif.mem_fwd_val = '0;
    bif.wb_wr_en = 0; bif.wb_wr_addr = '0; bif.wb_val = '0;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".br_cnt"}, 64'(bif.br_cnt), 64'(br_m));
    chk({tag, ".taken_cnt"}, 64'(bif.taken_cnt), 64'(tk_m));
  endtask

  // Waits for the falling edge, then checks the combinational outputs.
  task automatic chk_cyc(input string tag, input logic es, input logic et);
    logic [31:0] tgt;
    logic        efl;
    @(negedge clk);
    tgt = bif.id_pc_plus4 + {{14{bif.id_imm16[15]}}, bif.id_imm16, 2'b00};
`ifdef BR_FLUSH_EN
    efl = et;
`else
    efl = 1'b0;
`endif
    chk({tag, ".stall"}, 64'(bif.stall), 64'(es));
    chk({tag, ".br_taken"}, 64'(bif.br_taken), 64'(et));
    chk({tag, ".flush_if"}, 64'(bif.flush_if), 64'(efl));
    chk({tag, ".target"}, 64'(bif.br_target), 64'(tgt));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7;
      default: return $urandom;
    endcase
  endfunction

  function automatic prod_t rnd_prod();
    prod_t p;
    p.en  = 1'($urandom_range(0, 1));
    p.a   = 5'($urandom_range(0, 3));
    p.ld  = 1'($urandom_range(0, 1));
    p.res = pick();
    return p;
  endfunction

  // Architectural value of register s as seen by program order.
  function automatic logic [31:0] arch(input logic [4:0] s);
    if (s == 0) return 32'h0;
    if (ex_p.en && ex_p.a == s)   return ex_p.res;
    if (mem_p.en && mem_p.a == s) return mem_p.res;
    if (wb_p.en && wb_p.a == s)   return wb_p.res;
    return regs[s];
  endfunction

  // Cycles until the youngest producer of s reaches a forward point:
  // ALU results forward from MEM, load data only from WB.
  function automatic int need(input logic [4:0] s);
    if (s == 0) return 0;
    if (ex_p.en && ex_p.a == s)                return ex_p.ld ? 2 : 1;
    if (mem_p.en && mem_p.a == s && mem_p.ld) return 1;
    return 0;
  endfunction

  function automatic logic taken_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a == b;
      4'd1: return a != b;
      4'd4: return $signed(a) >= 0;
      4'd5: return $signed(a) > 0;
      4'd6: return $signed(a) <= 0;
      4'd7: return $signed(a) < 0;
      4'd8: return b == 0;
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0]  ops [10];
  logic [3:0]  op;
  logic [4:0]  rs, rt;
  logic [31:0] pc, av, bv;
  logic [15:0] imm;
  logic        exp_t, done;
  int          s_need, fl;

  initial begin
    ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd3, 4'd15};
    br_m = '0; tk_m = '0;
    reset = 1'b1;
    clear_in();
    #1;
    // Reset holds outputs low even with a hazarding branch present.
    bif.id_branch = 1; bif.id_rs = 5'd5; bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd5;
    #1;
    chk("rst.stall", 64'(bif.stall), 64'd0);
    chk("rst.br_taken", 64'(bif.br_taken), 64'd0);
    chk("rst.flush_if", 64'(bif.flush_if), 64'd0);
    chk_cnt("rst");
    clear_in();
    edge_();
    reset = 1'b0;

    // 1: beq no hazard, taken same cycle
    bif.id_branch = 1; bif.id_cmp_op = 4'd0; bif.id_rs = 5'd5; bif.id_rt = 5'd6;
    bif.id_rs_val = 32'd7; bif.id_rt_val = 32'd7;
    bif.id_pc_plus4 = 32'h0040_0004; bif.id_imm16 = 16'h0003;
    chk_cyc("t1", 0, 1);
    chk("t1.target_abs", 64'(bif.br_target), 64'h0040_0010);
    edge_();
    br_m = 1; tk_m = 1;
    chk_cnt("t1");
    clear_in();

    // 2: bne with EX ALU producer, then MEM forward
    bif.id_branch = 1; bif.id_cmp_op = 4'd1; bif.id_rs = 5'd5; bif.id_rt = 5'd6;
    bif.id_rs_val = 32'h9; bif.id_rt_val = 32'h1;
    bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd5;
    chk_cyc("t2a", 1, 0);
    edge_();
    chk_cnt("t2a");
    bif.ex_wr_en = 0; bif.mem_wr_en = 1; bif.mem_wr_addr = 5'd5; bif.mem_fwd_val = 32'h1;
    chk_cyc("t2b", 0, 0);
    edge_();
    br_m++;
    chk_cnt("t2b");
    clear_in();

    // 3: bgtz with EX load producer, WB value after 2 stalls
    bif.id_branch = 1; bif.id_cmp_op = 4'd5; bif.id_rs = 5'd8; bif.id_rs_val = 32'h5;
    bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd8; bif.ex_is_load = 1;
    chk_cyc("t3a", 1, 0);
    edge_();
    bif.ex_wr_en = 0; bif.ex_is_load = 0;
    bif.mem_wr_en = 1; bif.mem_wr_addr = 5'd8; bif.mem_is_load = 1; bif.mem_fwd_val = 32'h55;
    chk_cyc("t3b", 1, 0);
    edge_();
    bif.mem_wr_en = 0; bif.mem_is_load = 0;
    bif.wb_wr_en = 1; bif.wb_wr_addr = 5'd8; bif.wb_val = 32'h0;
    chk_cyc("t3c", 0, 0);
    edge_();
    br_m++;
    chk_cnt("t3");
    clear_in();

    // 4: beq $0,$0 with EX writing $0, backward target wraps
    bif.id_branch = 1; bif.id_cmp_op = 4'd0; bif.id_pc_plus4 = 32'h0; bif.id_imm16 = 16'hFFFF;
    bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd0; bif.ex_is_load = 1;
    chk_cyc("t4", 0, 1);
    chk("t4.target_abs", 64'(bif.br_target), 64'hFFFF_FFFC);
    edge_();
    br_m++; tk_m++;
    chk_cnt("t4");
    clear_in();

    // 5a: flush while waiting
    bif.id_branch = 1; bif.id_cmp_op = 4'd0; bif.id_rs = 5'd3; bif.id_rt = 5'd4;
    bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd3; bif.ex_is_load = 1;
    chk_cyc("t5a", 1, 0);
    edge_();
    bif.ex_wr_en = 0; bif.ex_is_load = 0;
    bif.mem_wr_en = 1; bif.mem_wr_addr = 5'd3; bif.mem_is_load = 1; bif.flush_id = 1;
    chk_cyc("t5a.flush", 0, 0);
    edge_();
    chk_cnt("t5a");
    clear_in();
    chk_cyc("t5a.idle", 0, 0);
    edge_();

    // 5b: reset while waiting
    bif.id_branch = 1; bif.id_cmp_op = 4'd0; bif.id_rs = 5'd3; bif.id_rt = 5'd4;
    bif.ex_wr_en = 1; bif.ex_wr_addr = 5'd3; bif.ex_is_load = 1;
    chk_cyc("t5b", 1, 0);
    edge_();
    bif.ex_wr_en = 0; bif.ex_is_load = 0;
    bif.mem_wr_en = 1; bif.mem_wr_addr = 5'd3; bif.mem_is_load = 1;
    #1 reset = 1'b1;
    #1;
    br_m = '0; tk_m = '0;
    chk("t5b.stall", 64'(bif.stall), 64'd0);
    chk("t5b.br_taken", 64'(bif.br_taken), 64'd0);
    chk("t5b.flush_if", 64'(bif.flush_if), 64'd0);
    chk_cnt("t5b");
    clear_in();
    edge_();
    reset = 1'b0;
    chk_cyc("t5b.idle", 0, 0);
    edge_();

    // 6: unlisted op counted not taken; then a taken bltz
    bif.id_branch = 1; bif.id_cmp_op = 4'b0011; bif.id_rs = 5'd1; bif.id_rt = 5'd2;
    chk_cyc("t6a", 0, 0);
    edge_();
    br_m++;
    chk_cnt("t6a");
    bif.id_cmp_op = 4'd7; bif.id_rs_val = 32'h8000_0000;
    chk_cyc("t6b", 0, 1);
    edge_();
    br_m++; tk_m++;
    chk_cnt("t6b");
    clear_in();

    // Randomized branches against the architectural model.
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : pick();
    for (int n = 0; n < 400; n++) begin
      ex_p = rnd_prod(); mem_p = rnd_prod(); wb_p = rnd_prod();
      op  = ops[$urandom_range(0, 9)];
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      pc  = $urandom;
      imm = 16'($urandom);
      av  = arch(rs);
      bv  = arch(rt);
      exp_t  = taken_of(op, av, bv);
      s_need = 0;
      if (op != 4'd8 && need(rs) > s_need) s_need = need(rs);
      if ((op == 4'd0 || op == 4'd1 || op == 4'd8) && need(rt) > s_need) s_need = need(rt);
      fl   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, s_need)) : -1;
      done = 1'b0;
      for (int k = 0; k <= s_need && !done; k++) begin
        bif.id_branch = 1; bif.id_cmp_op = op; bif.id_rs = rs; bif.id_rt = rt;
        bif.id_rs_val = regs[rs]; bif.id_rt_val = regs[rt];
        bif.id_pc_plus4 = pc; bif.id_imm16 = imm; bif.flush_id = (k == fl);
        bif.ex_wr_en = ex_p.en; bif.ex_wr_addr = ex_p.a; bif.ex_is_load = ex_p.ld;
        bif.mem_wr_en = mem_p.en; bif.mem_wr_addr = mem_p.a; bif.mem_is_load = mem_p.ld;
        bif.mem_fwd_val = mem_p.ld ? $urandom : mem_p.res;
        bif.wb_wr_en = wb_p.en; bif.wb_wr_addr = wb_p.a; bif.wb_val = wb_p.res;
        if (k == fl)          chk_cyc("rnd.flush", 0, 0);
        else if (k < s_need)  chk_cyc("rnd.stall", 1, 0);
        else                  chk_cyc("rnd.resolve", 0, exp_t);
        edge_();
        if (k == fl) done = 1'b1;
        else if (k == s_need) begin
          br_m++;
          if (exp_t) tk_m++;
        end
        chk_cnt("rnd");
        // Advance the pipeline: WB retires, a bubble enters EX.
        if (wb_p.en && wb_p.a != 0) regs[wb_p.a] = wb_p.res;
        wb_p  = mem_p;
        mem_p = ex_p;
        ex_p  = '0;
      end
      clear_in();
      chk_cyc("rnd.idle", 0, 0);
      edge_();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
